// File: rtl/alu_wide_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_wide_seq
// Brief    : Runs 32-bit commands as two 16-bit steps on an external ALU.
// Revision : 1.0
// ============================================================================
module alu_wide_seq #(
    parameter logic [2:0] IDLE_OP = 3'b110
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_cmd,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [3:0]  rsp_flags,
    output logic [2:0]  alu_op,
    output logic [3:0]  alu_func,
    output logic [15:0] alu_s1,
    output logic [15:0] alu_s2,
    input  logic [15:0] alu_result,
    input  logic [3:0]  alu_flags
);

    localparam logic [2:0] CMD_ADD  = 3'b000;
    localparam logic [2:0] CMD_AND  = 3'b001;
    localparam logic [2:0] CMD_OR   = 3'b010;
    localparam logic [2:0] CMD_XOR  = 3'b011;
    localparam logic [2:0] CMD_SHL  = 3'b100;
    localparam logic [2:0] CMD_SHR  = 3'b101;
    localparam logic [2:0] CMD_SSHR = 3'b110;
    localparam logic [2:0] CMD_NOT  = 3'b111;
    localparam logic [2:0] OP_STEP  = 3'b000;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LO   = 3'd1,
        S_HI   = 3'd2,
        S_FLG  = 3'd3,
        S_RSP  = 3'd4
    } state_t;

    state_t      state;
    logic [2:0]  cmd_q;
    logic [31:0] a_q;
    logic [31:0] b_q;

    // Right shifts walk from the top half down so the carry enters bit 15 of the low half.
    function automatic logic upper_first(input logic [2:0] cmd);
        return (cmd == CMD_SHR) || (cmd == CMD_SSHR);
    endfunction

    // Returns {func, s1, s2} for one step of a command.
    function automatic logic [35:0] step_drive(input logic [2:0] cmd, input logic [31:0] a,
                                               input logic [31:0] b, input logic second);
        logic        use_hi;
        logic [15:0] a_h;
        logic [15:0] b_h;
        logic [3:0]  func;
        logic [15:0] s1;
        logic [15:0] s2;
        use_hi = upper_first(cmd) ? ~second : second;
        a_h    = use_hi ? a[31:16] : a[15:0];
        b_h    = use_hi ? b[31:16] : b[15:0];
        func   = 4'b0000;
        s1     = 16'd0;
        s2     = a_h;
        case (cmd)
            CMD_ADD:  begin func = second ? 4'b0010 : 4'b0001; s1 = a_h; s2 = b_h; end
            CMD_AND:  begin func = 4'b0101; s1 = a_h; s2 = b_h; end
            CMD_OR:   begin func = 4'b0011; s1 = a_h; s2 = b_h; end
            CMD_XOR:  begin func = 4'b0111; s1 = a_h; s2 = b_h; end
            CMD_SHL:  func = second ? 4'b1111 : 4'b1001;
            CMD_SHR:  func = second ? 4'b1110 : 4'b1010;
            CMD_SSHR: func = second ? 4'b1110 : 4'b1101;
            CMD_NOT:  func = 4'b1000;
            default:  func = 4'b0000;
        endcase
        return {func, s1, s2};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cmd_q      <= 3'd0;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_result <= 32'd0;
            rsp_flags  <= 4'd0;
            alu_op     <= IDLE_OP;
            alu_func   <= 4'd0;
            alu_s1     <= 16'd0;
            alu_s2     <= 16'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        cmd_q     <= req_cmd;
                        a_q       <= req_a;
                        b_q       <= req_b;
                        req_ready <= 1'b0;
                        alu_op    <= OP_STEP;
                        {alu_func, alu_s1, alu_s2} <= step_drive(req_cmd, req_a, req_b, 1'b0);
                        state     <= S_LO;
                    end
                end
                S_LO: begin
                    if (upper_first(cmd_q)) rsp_result[31:16] <= alu_result;
                    else                    rsp_result[15:0]  <= alu_result;
                    {alu_func, alu_s1, alu_s2} <= step_drive(cmd_q, a_q, b_q, 1'b1);
                    state <= S_HI;
                end
                S_HI: begin
                    if (upper_first(cmd_q)) rsp_result[15:0]  <= alu_result;
                    else                    rsp_result[31:16] <= alu_result;
                    alu_op   <= IDLE_OP;
                    alu_func <= 4'd0;
                    alu_s1   <= 16'd0;
                    alu_s2   <= 16'd0;
                    state    <= S_FLG;
                end
                S_FLG: begin
                    // alu_flags now hold the registered flags of the second step.
                    rsp_flags <= {(cmd_q == CMD_ADD) && alu_flags[3],
                                  rsp_result[31],
                                  rsp_result == 32'd0,
                                  ((cmd_q == CMD_ADD) || (cmd_q == CMD_SHL) ||
                                   (cmd_q == CMD_SHR) || (cmd_q == CMD_SSHR)) && alu_flags[0]};
                    rsp_valid <= 1'b1;
                    state     <= S_RSP;
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
